instruction_fetch_unit: RTL and testbench

Fetch stage of the multi-cycle RISC core; sits directly upstream of the control unit.
- Owns the PC and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Latches each word into an instruction register and decodes its fields (type, function code, register indices, immediates) for the control unit and register file.
- Next-PC selection follows the control unit's 2-bit pc-source signal.

---
 rtl/risc_pkg.sv | 41 ++++
 rtl/next_pc_sel.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared encodings, IR field positions and fetch FSM states for the RISC core
package risc_pkg;

    typedef enum logic [1:0] {
        INSTR_R = 2'd0,
        INSTR_S = 2'd1,
        INSTR_I = 2'd2,
        INSTR_J = 2'd3
    } instr_type_e;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RET    = 2'd3
    } pc_src_e;

    // Shared with the control unit's stage sequencing.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int FC_MSB    = 31;
    localparam int FC_LSB    = 27;
    localparam int TYPE_MSB  = 26;
    localparam int TYPE_LSB  = 25;
    localparam int RS1_MSB   = 24;
    localparam int RS1_LSB   = 21;
    localparam int RD_MSB    = 20;
    localparam int RD_LSB    = 17;
    localparam int RS2_MSB   = 16;
    localparam int RS2_LSB   = 13;
    localparam int IMM16_MSB = 16;
    localparam int IMM16_LSB = 1;
    localparam int IMM24_MSB = 24;
    localparam int IMM24_LSB = 1;
    localparam int STOP_BIT  = 0;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - combinational next-PC selection from pc-source, immediates and return address
module next_pc_sel
    import risc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [1:0]            sig_pc_src,
    input  logic [15:0]           imm16,
    input  logic [23:0]           imm24,
    input  logic [ADDR_WIDTH-1:0] return_addr,
    input  logic                  first_fetch,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    logic [ADDR_WIDTH-1:0] off16;
    logic [ADDR_WIDTH-1:0] off24;

    assign off16 = ADDR_WIDTH'($signed(imm16));
    assign off24 = ADDR_WIDTH'($signed(imm24));

    // Sums wrap modulo 2^ADDR_WIDTH by construction.
    always_comb begin
        next_pc = pc + ADDR_WIDTH'(1);
        if (first_fetch) begin
            next_pc = RESET_PC;
        end else begin
            case (pc_src_e'(sig_pc_src))
                PC_INC:    next_pc = pc + ADDR_WIDTH'(1);
                PC_BRANCH: next_pc = pc + off16;
                PC_JUMP:   next_pc = pc + off24;
                PC_RET:    next_pc = return_addr;
                default:   next_pc = pc + ADDR_WIDTH'(1);
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, imem req/ack fetch FSM, IR and field decode; FETCH_STALL_CNT_EN adds stall/fetch counters
module instruction_fetch_unit
    import risc_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
`ifdef FETCH_STALL_CNT_EN
    ,
    parameter int                    STALL_CNT_WIDTH = 16
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en_instruction_fetch,
    input  logic [1:0]            sig_pc_src,
    input  logic [ADDR_WIDTH-1:0] return_addr,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  instr_valid,
    output logic [1:0]            InstructionType,
    output logic [4:0]            FunctionCode,
    output logic [3:0]            rs1,
    output logic [3:0]            rd,
    output logic [3:0]            rs2,
    output logic [15:0]           imm16,
    output logic [23:0]           imm24,
    output logic                  stop_bit
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles,
    output logic [31:0]                fetch_count
`endif
);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic                  first_fetch;
    logic [31:0]           ir;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  start_fetch;
    logic                  accept;

    assign FunctionCode    = ir[FC_MSB:FC_LSB];
    assign InstructionType = ir[TYPE_MSB:TYPE_LSB];
    assign rs1             = ir[RS1_MSB:RS1_LSB];
    assign rd              = ir[RD_MSB:RD_LSB];
    assign rs2             = ir[RS2_MSB:RS2_LSB];
    assign imm16           = ir[IMM16_MSB:IMM16_LSB];
    assign imm24           = ir[IMM24_MSB:IMM24_LSB];
    assign stop_bit        = ir[STOP_BIT];

    next_pc_sel #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_next_pc_sel (
        .pc          (pc),
        .sig_pc_src  (sig_pc_src),
        .imm16       (imm16),
        .imm24       (imm24),
        .return_addr (return_addr),
        .first_fetch (first_fetch),
        .next_pc     (next_pc)
    );

    // An en pulse while a fetch is outstanding is dropped, not queued.
    always_comb begin
        state_d     = state_q;
        start_fetch = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (en_instruction_fetch) begin
                    start_fetch = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    accept  = 1'b1;
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first_fetch <= 1'b1;
            pc          <= RESET_PC;
            ir          <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
        end else if (start_fetch) begin
            first_fetch <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= next_pc;
            instr_valid <= 1'b0;
        end else if (accept) begin
            ir          <= imem_rdata;
            pc          <= imem_addr;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            fetch_count  <= '0;
        end else begin
            if (state_q == REQ && !imem_ack && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
            end
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized bench with transaction-level reference model for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  src = 2'd0;
    logic [31:0] ret_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [31:0] pc;
    logic        instr_valid;
    logic [1:0]  InstructionType;
    logic [4:0]  FunctionCode;
    logic [3:0]  rs1, rd, rs2;
    logic [15:0] imm16;
    logic [23:0] imm24;
    logic        stop_bit;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
    logic [31:0] fetch_count;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit #(
        .ADDR_WIDTH (32),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .en_instruction_fetch (en),
        .sig_pc_src           (src),
        .return_addr          (ret_addr),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (ack),
        .imem_rdata           (rdata),
        .pc                   (pc),
        .instr_valid          (instr_valid),
        .InstructionType      (InstructionType),
        .FunctionCode         (FunctionCode),
        .rs1                  (rs1),
        .rd                   (rd),
        .rs2                  (rs2),
        .imm16                (imm16),
        .imm24                (imm24),
        .stop_bit             (stop_bit)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles         (stall_cycles),
        .fetch_count          (fetch_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch is either outstanding or not; the IR/pc pair is whatever was last acked.
    logic        m_busy;
    logic [31:0] m_addr, m_pc, m_ir;
    logic        m_valid, m_first;
    int          m_stall, m_fetches;

    function automatic logic [31:0] target(input logic [31:0] cur_pc, input logic [1:0] s,
                                           input logic [31:0] cur_ir, input logic [31:0] ra);
        logic [15:0] i16;
        logic [23:0] i24;
        i16 = 16'((cur_ir >> 1) & 32'hFFFF);
        i24 = 24'((cur_ir >> 1) & 32'hFF_FFFF);
        case (s)
            2'd0:    return cur_pc + 32'd1;
            2'd1:    return cur_pc + 32'($signed(i16));
            2'd2:    return cur_pc + 32'($signed(i24));
            default: return ra;
        endcase
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_addr = RESET_PC; m_pc = RESET_PC; m_ir = 32'h0;
            m_valid = 1'b0; m_first = 1'b1; m_stall = 0; m_fetches = 0;
        end else if (m_busy) begin
            if (ack) begin
                m_ir = rdata; m_pc = m_addr; m_busy = 1'b0; m_valid = 1'b1; m_fetches++;
            end else if (m_stall < 65535) begin
                m_stall++;
            end
        end else if (en) begin
            m_addr  = m_first ? RESET_PC : target(m_pc, src, m_ir, ret_addr);
            m_busy  = 1'b1; m_valid = 1'b0; m_first = 1'b0;
        end
    end

    always @(negedge clock) begin
        check("imem_req", imem_req, m_busy);
        check("imem_addr", imem_addr, m_addr);
        check("instr_valid", instr_valid, m_valid);
        check("pc", pc, m_pc);
        check("FunctionCode", FunctionCode, m_ir >> 27);
        check("InstructionType", InstructionType, (m_ir >> 25) & 3);
        check("rs1", rs1, (m_ir >> 21) & 15);
        check("rd", rd, (m_ir >> 17) & 15);
        check("rs2", rs2, (m_ir >> 13) & 15);
        check("imm16", imm16, (m_ir >> 1) & 32'hFFFF);
        check("imm24", imm24, (m_ir >> 1) & 32'hFF_FFFF);
        check("stop_bit", stop_bit, m_ir & 1);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("fetch_count", fetch_count, m_fetches);
`endif
    end

    task automatic fetch(input logic [1:0] s, input logic [31:0] ra, input logic [31:0] data,
                         input int delay, input bit extra_en, output logic [31:0] req_addr);
        @(posedge clock); #1;
        en = 1'b1; src = s; ret_addr = ra; ack = 1'b0;
        @(posedge clock); #1;
        en = 1'b0;
        req_addr = imem_addr;
        for (int i = 0; i < delay; i++) begin
            if (extra_en && i == 0) begin
                en = 1'b1;
                $display("note: en pulsed during REQ (protocol error, must be ignored)");
            end
            @(posedge clock); #1;
            en = 1'b0;
        end
        ack = 1'b1; rdata = data;
        @(posedge clock); #1;
        ack = 1'b0; rdata = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            ack = 1'($urandom % 2); rdata = $urandom;
        end
        @(posedge clock); #1;
        ack = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #3;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    logic [31:0] a;
    logic [31:0] p0;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset imem_req", imem_req, 0);
        check("reset imem_addr", imem_addr, RESET_PC);
        check("reset instr_valid", instr_valid, 0);
        check("reset FunctionCode", FunctionCode, 0);
        reset_n = 1'b1;

        fetch(2'd3, 32'h55, 32'h1234_5678, 0, 1'b0, a);
        check("first addr", a, 32'h0);
        check("first pc", pc, 32'h0);
        check("first FunctionCode", FunctionCode, 5'h02);
        check("first InstructionType", InstructionType, 2'd1);
        check("first instr_valid", instr_valid, 1);

        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            fetch(2'd0, 32'h0, $urandom, 3, 1'b0, a);
            check("seq addr", a, k);
        end
`ifdef FETCH_STALL_CNT_EN
        check("stall_cycles after 3x3 waits", stall_cycles, 9);
        check("fetch_count after 3", fetch_count, 3);
`endif

        fetch(2'd3, 32'h10, 32'h0001_FFF8, 1, 1'b0, a);
        check("ret to 0x10", a, 32'h10);
        fetch(2'd1, 32'h0, 32'h0, 0, 1'b0, a);
        check("branch -4", a, 32'h0C);
        fetch(2'd3, 32'h10, 32'h0000_0200, 0, 1'b0, a);
        fetch(2'd2, 32'h0, 32'h0, 2, 1'b0, a);
        check("jump +0x100", a, 32'h110);
        fetch(2'd3, 32'hFFFF_FFFF, $urandom, 0, 1'b0, a);
        check("ret to all-ones", a, 32'hFFFF_FFFF);
        fetch(2'd0, 32'h0, $urandom, 1, 1'b0, a);
        check("inc wraps to 0", a, 32'h0);
        fetch(2'd3, 32'h40, $urandom, 0, 1'b0, a);
        check("ret 0x40", a, 32'h40);

        p0 = pc;
        fetch(2'd0, 32'h0, $urandom, 2, 1'b1, a);
        idle(3);
        check("en in REQ: single pc update", pc, p0 + 32'd1);
        check("en in REQ: no second request", imem_req, 0);

        @(posedge clock); #1;
        en = 1'b1; src = 2'd0;
        @(posedge clock); #1;
        en = 1'b0;
        check("mid-REQ req up", imem_req, 1);
        #2;
        reset_n = 1'b0; ack = 1'b1; rdata = $urandom;
        #1;
        check("reset drops req", imem_req, 0);
        check("reset clears valid", instr_valid, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        ack = 1'b0;
        check("late ack ignored", instr_valid, 0);
        fetch(2'd2, 32'h0, $urandom, 0, 1'b0, a);
        check("post-abort addr", a, RESET_PC);

        for (int k = 0; k < 40; k++) begin
            fetch(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3),
                  1'($urandom_range(0, 7) == 0), a);
            idle($urandom_range(0, 3));
        end

        @(posedge clock); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
